pc_call_stack: RTL and testbench

//   Parametrised next-generation program counter. Keeps the JMP/JMPC/JMPZ absolute
//   and relative branches and adds CALL, CALL_REL and RET, backed by a hardware

---
 rtl/pc_pkg.sv | 33 +++
 rtl/pc_call_stack_if.sv | 35 +++
 rtl/pc_return_stack.sv | 58 +++++
 rtl/pc_call_stack.sv | 140 ++++++++++++++
 tb/tb_pc_call_stack.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter with return-address stack.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: opcode select codes, branch operation enum, ALU flag bit indices.
package pc_pkg;

  // opcode[15:12]: where the branch target comes from
  localparam logic [3:0] PC_RAM_OP = 4'b0111;
  localparam logic [3:0] PC_ROM_OP = 4'b1111;

  // opcode[11:8]: branch operation; codes 9-15 fall through to pc+1
  typedef enum logic [3:0] {
    OP_JMP      = 4'd0,
    OP_JMPC     = 4'd1,
    OP_JMPZ     = 4'd2,
    OP_JMP_REL  = 4'd3,
    OP_JMPC_REL = 4'd4,
    OP_JMPZ_REL = 4'd5,
    OP_CALL     = 4'd6,
    OP_CALL_REL = 4'd7,
    OP_RET      = 4'd8
  } pc_op_e;

  // ALU flags are {X, X, C, Z}
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  // Only the RAM and ROM selects carry a branch; anything else is a plain step
  function automatic logic is_branch_select(input logic [3:0] sel);
    return (sel == PC_RAM_OP) || (sel == PC_ROM_OP);
  endfunction

endpackage

// File: rtl/pc_call_stack_if.sv
// Decoder/ALU-side bundle of the program counter: control in, status out.
// Latency: n/a (wiring only).
// Backpressure: none; pc_enable is the only qualifier of a cycle.
// master: decoder side (drives opcode/operands/flags/strobes); slave: the pc block.
interface pc_call_stack_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 8
);
  localparam int LW = $clog2(STACK_DEPTH) + 1;

  logic                  pc_enable;
  logic [DATA_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] data;
  logic [3:0]            flags;
  logic                  read_enable;
  logic                  fault_clear;

  logic [DATA_WIDTH-1:0] pc_debug_output;
  logic [LW-1:0]         stack_level;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  stack_fault;

  modport master (
    output pc_enable, opcode, operand, data, flags, read_enable, fault_clear,
    input  pc_debug_output, stack_level, stack_full, stack_empty, stack_fault
  );

  modport slave (
    input  pc_enable, opcode, operand, data, flags, read_enable, fault_clear,
    output pc_debug_output, stack_level, stack_full, stack_empty, stack_fault
  );

endinterface

// File: rtl/pc_return_stack.sv
// LIFO of return addresses: push writes entry[level], pop exposes entry[level-1].
// Latency: push/pop take effect on the next clk edge; top_dat is combinational.
// Backpressure: push while full and pop while empty are ignored (caller flags it).
// Ports: clk, reset_n, push, pop, push_dat in; top_dat, level, full, empty out.
module pc_return_stack #(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 8,
  localparam int LW = $clog2(STACK_DEPTH) + 1,
  localparam int AW = $clog2(STACK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_dat,
  output logic [DATA_WIDTH-1:0] top_dat,
  output logic [LW-1:0]         level,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [STACK_DEPTH];
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (level == LW'(STACK_DEPTH));
  assign empty = (level == '0);

  // Depth is a power of two, so the low bits of level index the array directly;
  // at level==STACK_DEPTH they wrap to 0 and minus one lands on the last entry.
  assign wr_idx = level[AW-1:0];
  assign rd_idx = level[AW-1:0] - AW'(1);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  assign top_dat = mem[rd_idx];

  // Storage is deliberately not reset; only the level defines valid entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
    end else if (do_push) begin
      level <= level + LW'(1);
    end else if (do_pop) begin
      level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with absolute/relative/conditional jumps, CALL/CALL_REL/RET.
// Latency: one clk; pc, stack and fault update on the edge where pc_enable=1.
// Backpressure: none; pc_enable=0 freezes all state (fault_clear still acts).
// Ports: clk, reset_n (async, active-low), bus (pc_call_stack_if.slave),
//   pc (tri-stated bus copy of the pc, driven only while read_enable is high).
// Build option: define PC_STACK_TRAP_EN to send overflow/underflow to TRAP_VECTOR;
//   otherwise an overflowing CALL jumps without pushing and an empty RET steps.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    STACK_DEPTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pc_call_stack_if.slave        bus,
  output wire  [DATA_WIDTH-1:0] pc
);

  localparam int LW = $clog2(STACK_DEPTH) + 1;

`ifdef PC_STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] pc_register;
  logic                  stack_fault_q;

  logic [3:0]            sel;
  pc_op_e                op;
  logic [DATA_WIDTH-1:0] tgt;
  logic [DATA_WIDTH-1:0] pc_inc;
  logic [DATA_WIDTH-1:0] pc_rel;
  logic [DATA_WIDTH-1:0] call_tgt;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  push_req;
  logic                  pop_req;
  logic                  overflow;
  logic                  underflow;

  logic [DATA_WIDTH-1:0] stk_top;
  logic [LW-1:0]         stk_level;
  logic                  stk_full;
  logic                  stk_empty;

  // Flag bits 3:2 carry no meaning for branching.
  logic                  unused_flags;
  assign unused_flags = ^bus.flags[3:2];

  assign sel      = bus.opcode[15:12];
  assign op       = pc_op_e'(bus.opcode[11:8]);
  assign tgt      = (sel == PC_RAM_OP) ? bus.data : bus.operand;
  assign pc_inc   = pc_register + DATA_WIDTH'(1);
  assign pc_rel   = pc_register + tgt;
  assign call_tgt = (op == OP_CALL) ? tgt : pc_rel;

  always_comb begin
    next_pc   = pc_inc;
    push_req  = 1'b0;
    pop_req   = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (is_branch_select(sel)) begin
      case (op)
        OP_JMP:      next_pc = tgt;
        OP_JMPC:     if (bus.flags[FLAG_C]) next_pc = tgt;
        OP_JMPZ:     if (bus.flags[FLAG_Z]) next_pc = tgt;
        OP_JMP_REL:  next_pc = pc_rel;
        OP_JMPC_REL: if (bus.flags[FLAG_C]) next_pc = pc_rel;
        OP_JMPZ_REL: if (bus.flags[FLAG_Z]) next_pc = pc_rel;
        OP_CALL, OP_CALL_REL: begin
          if (stk_full) begin
            overflow = 1'b1;
            next_pc  = TRAP_EN ? TRAP_VECTOR : call_tgt;
          end else begin
            push_req = 1'b1;
            next_pc  = call_tgt;
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            underflow = 1'b1;
            next_pc   = TRAP_EN ? TRAP_VECTOR : pc_inc;
          end else begin
            pop_req = 1'b1;
            next_pc = stk_top;
          end
        end
        default: ;
      endcase
    end
  end

  pc_return_stack #(
    .DATA_WIDTH (DATA_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.pc_enable && push_req),
    .pop     (bus.pc_enable && pop_req),
    .push_dat(pc_inc),
    .top_dat (stk_top),
    .level   (stk_level),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_register <= RESET_VECTOR;
    end else if (bus.pc_enable) begin
      pc_register <= next_pc;
    end
  end

  // A fault raised this cycle beats a simultaneous clear; the clear alone works
  // even while the pc is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stack_fault_q <= 1'b0;
    end else if (bus.pc_enable && (overflow || underflow)) begin
      stack_fault_q <= 1'b1;
    end else if (bus.fault_clear) begin
      stack_fault_q <= 1'b0;
    end
  end

  assign pc                  = bus.read_enable ? pc_register : 'z;
  assign bus.pc_debug_output = pc_register;
  assign bus.stack_level     = stk_level;
  assign bus.stack_full      = stk_full;
  assign bus.stack_empty     = stk_empty;
  assign bus.stack_fault     = stack_fault_q;

endmodule

// File: tb/tb_pc_call_stack.sv
module tb_pc_call_stack;
  import pc_pkg::*;

  localparam int          DW   = 16;
  localparam int          SD   = 8;
  localparam logic [15:0] TRAP = 16'h0BAD;
`ifdef PC_STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  wire  [15:0] pc_bus;

  pc_call_stack_if #(.DATA_WIDTH(DW), .STACK_DEPTH(SD)) bus ();

  pc_call_stack #(
    .DATA_WIDTH  (DW),
    .STACK_DEPTH (SD),
    .RESET_VECTOR(16'h0000),
    .TRAP_VECTOR (TRAP)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .pc     (pc_bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: pc value, return addresses as a queue, sticky fault bit
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_stk[$];
  logic        m_fault = 1'b0;

  typedef struct {
    logic [15:0] opc;
    logic [15:0] opd;
    logic [15:0] dat;
    logic [3:0]  flg;
    logic [15:0] exp_pc;
    int          exp_lvl;
  } vec_t;
  vec_t tbl[20];

  function automatic logic [15:0] mk(input logic [3:0] s, input logic [3:0] o);
    return {s, o, 8'h00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_released(input string name);
    n_cmp++;
    if (!((pc_bus === 16'hzzzz) || (pc_bus === 16'h0000))) begin
      n_fail++;
      $display("FAIL %s: bus shows 0x%0h, expected released (z)", name, pc_bus);
    end
  endtask

  task automatic model_reset();
    m_pc    = 16'h0000;
    m_stk   = {};
    m_fault = 1'b0;
  endtask

  // One enabled/disabled cycle computed straight from the operation rules
  task automatic model_step();
    logic [3:0]  s;
    int          o;
    logic [15:0] t, nxt, ct;
    logic        flt;
    if (!bus.pc_enable) begin
      if (bus.fault_clear) m_fault = 1'b0;
      return;
    end
    s   = bus.opcode[15:12];
    o   = int'(bus.opcode[11:8]);
    t   = (s == 4'h7) ? bus.data : bus.operand;
    nxt = m_pc + 16'd1;
    flt = 1'b0;
    if (s == 4'h7 || s == 4'hF) begin
      case (o)
        0: nxt = t;
        1: if (bus.flags[1]) nxt = t;
        2: if (bus.flags[0]) nxt = t;
        3: nxt = m_pc + t;
        4: if (bus.flags[1]) nxt = m_pc + t;
        5: if (bus.flags[0]) nxt = m_pc + t;
        6, 7: begin
          ct = (o == 6) ? t : m_pc + t;
          if (m_stk.size() == SD) begin
            flt = 1'b1;
            nxt = TRAP_EN ? TRAP : ct;
          end else begin
            m_stk.push_back(m_pc + 16'd1);
            nxt = ct;
          end
        end
        8: begin
          if (m_stk.size() == 0) begin
            flt = 1'b1;
            nxt = TRAP_EN ? TRAP : m_pc + 16'd1;
          end else begin
            nxt = m_stk.pop_back();
          end
        end
        default: ;
      endcase
    end
    if (flt) m_fault = 1'b1;
    else if (bus.fault_clear) m_fault = 1'b0;
    m_pc = nxt;
  endtask

  task automatic drive(input logic en, input logic [15:0] o, input logic [15:0] opd,
                       input logic [15:0] dat, input logic [3:0] flg,
                       input logic re, input logic fc);
    bus.pc_enable   = en;
    bus.opcode      = o;
    bus.operand     = opd;
    bus.data        = dat;
    bus.flags       = flg;
    bus.read_enable = re;
    bus.fault_clear = fc;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name);
    check({name, ".pc_dbg"}, 32'(bus.pc_debug_output), 32'(m_pc));
    check({name, ".level"},  32'(bus.stack_level), 32'(m_stk.size()));
    check({name, ".full"},   32'(bus.stack_full), 32'(m_stk.size() == SD));
    check({name, ".empty"},  32'(bus.stack_empty), 32'(m_stk.size() == 0));
    check({name, ".fault"},  32'(bus.stack_fault), 32'(m_fault));
    if (bus.read_enable) check({name, ".pc_bus"}, 32'(pc_bus), 32'(m_pc));
    else                 check_released({name, ".pc_bus"});
  endtask

  task automatic run(input logic en, input logic [15:0] o, input logic [15:0] opd,
                     input logic [15:0] dat, input logic [3:0] flg,
                     input logic re, input logic fc, input string name);
    drive(en, o, opd, dat, flg, re, fc);
    tick();
    check_state(name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    drive(1'b0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.pc_dbg", 32'(bus.pc_debug_output), 32'h0);
    check("rst.level",  32'(bus.stack_level), 32'd0);
    check("rst.empty",  32'(bus.stack_empty), 32'd1);
    check("rst.full",   32'(bus.stack_full), 32'd0);
    check("rst.fault",  32'(bus.stack_fault), 32'd0);
    check_released("rst.pc_bus");
    reset_n = 1'b1;

    // ---------------- sequential counting, async reset ----------------
    for (int i = 0; i < 3; i++) begin
      run(1'b1, 16'h0000, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, "count");
      check("count.abs", 32'(bus.pc_debug_output), 32'(i + 1));
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst.pc_dbg", 32'(bus.pc_debug_output), 32'h0);
    check("async_rst.pc_bus", 32'(pc_bus), 32'h0);
    model_reset();
    #1;
    reset_n = 1'b1;

    // ---------------- table of single-cycle branches ----------------
    tbl[0]  = '{16'hF000, 16'h0100, 16'h0000, 4'h0, 16'h0100, 0};
    tbl[1]  = '{16'hF100, 16'h0040, 16'h0000, 4'h0, 16'h0101, 0};
    tbl[2]  = '{16'hF100, 16'h0040, 16'h0000, 4'h2, 16'h0040, 0};
    tbl[3]  = '{16'hF000, 16'h0100, 16'h0000, 4'h0, 16'h0100, 0};
    tbl[4]  = '{16'h7500, 16'h0999, 16'h0010, 4'h1, 16'h0110, 0};
    tbl[5]  = '{16'h7500, 16'h0999, 16'h0010, 4'h0, 16'h0111, 0};
    tbl[6]  = '{16'hF300, 16'hFFF0, 16'h0000, 4'h0, 16'h0101, 0};
    tbl[7]  = '{16'h7000, 16'h1234, 16'h0020, 4'h0, 16'h0020, 0};
    tbl[8]  = '{16'hF600, 16'h0200, 16'h0000, 4'h0, 16'h0200, 1};
    tbl[9]  = '{16'hF800, 16'h0000, 16'h0000, 4'h0, 16'h0021, 0};
    tbl[10] = '{16'h3000, 16'h5555, 16'h0000, 4'h3, 16'h0022, 0};
    tbl[11] = '{16'hF900, 16'h0000, 16'h0000, 4'h0, 16'h0023, 0};
    tbl[12] = '{16'h7700, 16'h0000, 16'h0010, 4'h0, 16'h0033, 1};
    tbl[13] = '{16'hF400, 16'h0005, 16'h0000, 4'h2, 16'h0038, 1};
    tbl[14] = '{16'hF000, 16'hFFFF, 16'h0000, 4'h0, 16'hFFFF, 1};
    tbl[15] = '{16'h0000, 16'h0000, 16'h0000, 4'h0, 16'h0000, 1};
    tbl[16] = '{16'hF800, 16'h0000, 16'h0000, 4'h0, 16'h0024, 0};
    tbl[17] = '{16'hF200, 16'h0ABC, 16'h0000, 4'h1, 16'h0ABC, 0};
    tbl[18] = '{16'hF100, 16'h1111, 16'h0000, 4'h1, 16'h0ABD, 0};
    tbl[19] = '{16'hF200, 16'h2222, 16'h0000, 4'h2, 16'h0ABE, 0};
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, tbl[i].opc, tbl[i].opd, tbl[i].dat, tbl[i].flg, 1'b1, 1'b0);
      tick();
      check($sformatf("vec%0d.pc", i),    32'(bus.pc_debug_output), 32'(tbl[i].exp_pc));
      check($sformatf("vec%0d.bus", i),   32'(pc_bus), 32'(tbl[i].exp_pc));
      check($sformatf("vec%0d.level", i), 32'(bus.stack_level), 32'(tbl[i].exp_lvl));
      check($sformatf("vec%0d.fault", i), 32'(bus.stack_fault), 32'd0);
    end

    // ---------------- nested calls, overflow, LIFO return ----------------
    run(1'b1, mk(PC_ROM_OP, OP_JMP), 16'h0300, 16'h0, 4'h0, 1'b1, 1'b0, "nest.jmp");
    for (int i = 0; i < 9; i++) begin
      run(1'b1, mk(PC_ROM_OP, OP_CALL), 16'(16'h1000 + i * 16), 16'h0, 4'h0, 1'b1, 1'b0, "nest.call");
      if (i == 6) check("nest.not_full7", 32'(bus.stack_full), 32'd0);
      if (i == 7) begin
        check("nest.full8",  32'(bus.stack_full), 32'd1);
        check("nest.level8", 32'(bus.stack_level), 32'd8);
        check("nest.fault8", 32'(bus.stack_fault), 32'd0);
      end
    end
    check("ovf.fault", 32'(bus.stack_fault), 32'd1);
    check("ovf.level", 32'(bus.stack_level), 32'd8);
    check("ovf.pc",    32'(bus.pc_debug_output), TRAP_EN ? 32'(TRAP) : 32'h1080);
    for (int k = 0; k < 8; k++) begin
      run(1'b1, mk(PC_ROM_OP, OP_RET), 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, "lifo.ret");
      check($sformatf("lifo.ret%0d", k), 32'(bus.pc_debug_output),
            (k == 7) ? 32'h0301 : 32'(16'h1000 + (6 - k) * 16 + 1));
    end
    check("lifo.empty", 32'(bus.stack_empty), 32'd1);

    // ---------------- underflow and fault_clear priority ----------------
    run(1'b1, 16'h0000, 16'h0, 16'h0, 4'h0, 1'b1, 1'b1, "clr1");
    check("clr1.fault", 32'(bus.stack_fault), 32'd0);
    run(1'b1, mk(PC_ROM_OP, OP_JMP), 16'h0400, 16'h0, 4'h0, 1'b1, 1'b0, "unf.jmp");
    run(1'b1, mk(PC_ROM_OP, OP_RET), 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, "unf.ret");
    check("unf.fault", 32'(bus.stack_fault), 32'd1);
    check("unf.pc",    32'(bus.pc_debug_output), TRAP_EN ? 32'(TRAP) : 32'h0401);
    run(1'b1, mk(PC_RAM_OP, OP_RET), 16'h0, 16'h0, 4'h0, 1'b1, 1'b1, "unf_clr");
    check("unf_clr.fault", 32'(bus.stack_fault), 32'd1);
    run(1'b1, 16'h0000, 16'h0, 16'h0, 4'h0, 1'b1, 1'b1, "clr2");
    check("clr2.fault", 32'(bus.stack_fault), 32'd0);

    // ---------------- bus release and pc_enable hold ----------------
    run(1'b1, mk(PC_ROM_OP, OP_JMP), 16'h1234, 16'h0, 4'h0, 1'b0, 1'b0, "rel");
    check("rel.pc_dbg", 32'(bus.pc_debug_output), 32'h1234);
    check_released("rel.bus");
    run(1'b1, mk(PC_ROM_OP, OP_CALL), 16'h2000, 16'h0, 4'h0, 1'b1, 1'b0, "hold.call");
    run(1'b0, mk(PC_ROM_OP, OP_CALL), 16'h7777, 16'h0, 4'h0, 1'b1, 1'b0, "hold.call_dis");
    check("hold.level", 32'(bus.stack_level), 32'd1);
    check("hold.pc",    32'(bus.pc_debug_output), 32'h2000);
    run(1'b1, mk(PC_ROM_OP, OP_RET), 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, "hold.ret");
    run(1'b1, mk(PC_ROM_OP, OP_RET), 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, "hold.unf");
    run(1'b0, mk(PC_ROM_OP, OP_JMP), 16'h5555, 16'h0, 4'h0, 1'b1, 1'b0, "hold.dis1");
    run(1'b0, mk(PC_ROM_OP, OP_RET), 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, "hold.dis2");
    check("hold.fault", 32'(bus.stack_fault), 32'd1);
    run(1'b0, 16'h0000, 16'h0, 16'h0, 4'h0, 1'b1, 1'b1, "hold.clr");
    check("hold.clr_fault", 32'(bus.stack_fault), 32'd0);
    run(1'b0, mk(PC_ROM_OP, OP_RET), 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, "hold.dis_unf");
    check("hold.no_fault", 32'(bus.stack_fault), 32'd0);

    // ---------------- randomized traffic against the model ----------------
    for (int i = 0; i < 600; i++) begin
      logic [3:0] s, o;
      case ($urandom_range(0, 3))
        0:       s = PC_RAM_OP;
        1, 2:    s = PC_ROM_OP;
        default: s = 4'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) o = 4'($urandom_range(6, 8));
      else                           o = 4'($urandom);
      run(($urandom_range(0, 7) != 0), mk(s, o), 16'($urandom), 16'($urandom),
          4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), "rand");
    end

    // ---------------- asynchronous reset from an arbitrary state ----------------
    #3;
    reset_n = 1'b0;
    #1;
    check("rst2.pc_dbg", 32'(bus.pc_debug_output), 32'h0);
    check("rst2.level",  32'(bus.stack_level), 32'd0);
    check("rst2.fault",  32'(bus.stack_fault), 32'd0);
    check("rst2.empty",  32'(bus.stack_empty), 32'd1);
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
